// File: rtl/a1_truth_fn_if.sv
`default_nettype none
// ============================================================================
// Module    : a1_truth_fn_if
// Purpose   : Signal bundle for the a1_truth_fn leaf cell. It carries the
//             function input vector, the counter clear, and all results.
// Signals   : i[2:0]        function input vector           (master -> slave)
//             cnt_clr       synchronous clear of hit_cnt    (master -> slave)
//             f             combinational function output   (slave -> master)
//             f_q           f registered one cycle          (slave -> master)
//             f_rise        registered 0->1 pulse of f      (slave -> master)
//             hit_cnt       saturating count of f=1 cycles  (slave -> master)
//             par           odd parity of i, or 0           (slave -> master)
// Revision  : 1.0 - initial release
// ============================================================================
interface a1_truth_fn_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       i;
  logic             cnt_clr;
  logic             f;
  logic             f_q;
  logic             f_rise;
  logic [CNT_W-1:0] hit_cnt;
  logic             par;

  modport master (
    output i, cnt_clr,
    input  f, f_q, f_rise, hit_cnt, par
  );

  modport slave (
    input  i, cnt_clr,
    output f, f_q, f_rise, hit_cnt, par
  );
endinterface
`default_nettype wire

// File: rtl/a1_truth_fn.sv
`default_nettype none
// ============================================================================
// Module    : a1_truth_fn
// Purpose   : 3-input Boolean function block. f = TRUTH_TABLE[i] with zero
//             latency, plus a registered copy, a rising-edge pulse and a
//             saturating count of cycles sampled with f=1.
// Ports     : clk           single clock, rising edge
//             rst           synchronous active-high reset
//             bus (slave)   i, cnt_clr in; f, f_q, f_rise, hit_cnt, par out
// Params    : TRUTH_TABLE   function table, default 8'hE8 (3-input majority)
//             CNT_W         width of hit_cnt (must match the interface)
// Config    : A1_PARITY_EN  defined   -> par = ^i (combinational)
//                           undefined -> par tied to 0
// Revision  : 1.0 - initial release
// ============================================================================
module a1_truth_fn #(
  parameter logic [7:0] TRUTH_TABLE = 8'hE8,
  parameter int         CNT_W       = 8
) (
  input  wire logic     clk,
  input  wire logic     rst,
  a1_truth_fn_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic             w_f;
  logic             r_f_q;
  logic             r_f_rise;
  logic [CNT_W-1:0] r_hit_cnt;

  // Table lookup: an unknown index yields X rather than a spurious 1.
  assign w_f = TRUTH_TABLE[bus.i];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f_q     <= 1'b0;
      r_f_rise  <= 1'b0;
      r_hit_cnt <= '0;
    end else begin
      r_f_q    <= w_f;
      r_f_rise <= w_f & ~r_f_q;
      // Clear wins over counting; the count holds at all-ones.
      if (bus.cnt_clr) begin
        r_hit_cnt <= '0;
      end else if (w_f && (r_hit_cnt != C_CNT_MAX)) begin
        r_hit_cnt <= r_hit_cnt + C_CNT_ONE;
      end
    end
  end

  assign bus.f       = w_f;
  assign bus.f_q     = r_f_q;
  assign bus.f_rise  = r_f_rise;
  assign bus.hit_cnt = r_hit_cnt;

`ifdef A1_PARITY_EN
  assign bus.par = ^bus.i;
`else
  assign bus.par = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_a1_truth_fn.sv
`default_nettype none
// ============================================================================
// Module    : tb_a1_truth_fn
// Purpose   : Self-checking bench for a1_truth_fn. A reference model pushes
//             expected register values into a queue when inputs are applied;
//             each test pops and compares them after the clock edge.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_a1_truth_fn;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic             f_q;
    logic             f_rise;
    logic [CNT_W-1:0] hit_cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic clk_en;
  int   n_checks;
  int   n_errors;

  logic [7:0]       tt;
  logic             m_fq;
  logic             m_rise;
  logic [CNT_W-1:0] m_cnt;
  logic             exp_f;
  exp_t             sb[$];

  a1_truth_fn_if #(.CNT_W(CNT_W)) bus ();

  a1_truth_fn #(.TRUTH_TABLE(8'hE8), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock only runs once enabled so the combinational sweep can run clockless.
  always #5 clk = clk_en & ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Drive inputs, advance the model and queue the post-edge expectation.
  task automatic apply(input logic [2:0] iv, input logic clr, input logic rv);
    exp_t e;
    bus.i       = iv;
    bus.cnt_clr = clr;
    rst         = rv;
    exp_f       = tt[iv];
    if (rv) begin
      m_fq   = 1'b0;
      m_rise = 1'b0;
      m_cnt  = '0;
    end else begin
      m_rise = exp_f & ~m_fq;
      m_fq   = exp_f;
      if (clr)                        m_cnt = '0;
      else if (exp_f && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    e.f_q = m_fq; e.f_rise = m_rise; e.hit_cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [7:0] want;
    want = 8'b1110_1000;
    for (int k = 0; k < 8; k++) begin
      bus.i = 3'(k);
      #10;
      n_checks++;
      if (bus.f !== want[k]) begin
        n_errors++;
        $display("FAIL comb_sweep i=%0d got f=%b want %b", k, bus.f, want[k]);
      end
    end
    bus.i = 3'bxxx;
    #10;
    n_checks++;
    if (bus.f === 1'b1) begin
      n_errors++;
      $display("FAIL comb_x got f=%b want not 1", bus.f);
    end
  endtask

  task automatic test_parity();
    logic exp_p;
    for (int k = 0; k < 8; k++) begin
      bus.i = 3'(k);
      #2;
`ifdef A1_PARITY_EN
      exp_p = ^(3'(k));
`else
      exp_p = 1'b0;
`endif
      n_checks++;
      if (bus.par !== exp_p) begin
        n_errors++;
        $display("FAIL parity i=%0d got par=%b want %b", k, bus.par, exp_p);
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      apply(3'b111, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (bus.f !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_f cyc=%0d got %b want 1", k, bus.f);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({bus.f_q, bus.f_rise, bus.hit_cnt} !== {1'b0, 1'b0, 8'd0} ||
          {bus.f_q, bus.f_rise, bus.hit_cnt} !== e) begin
        n_errors++;
        $display("FAIL reset_regs cyc=%0d got fq=%b rise=%b cnt=%0d want 0 0 0",
                 k, bus.f_q, bus.f_rise, bus.hit_cnt);
      end
    end
  endtask

  task automatic test_rise();
    exp_t       e;
    int         pulses;
    logic [2:0] seq[8];
    seq = '{3'b000, 3'b000, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011};
    pulses = 0;
    apply(3'b000, 1'b0, 1'b1);
    tick();
    void'(sb.pop_front());
    for (int k = 0; k < 8; k++) begin
      apply(seq[k], 1'b0, 1'b0);
      tick();
      e = sb.pop_front();
      if (bus.f_rise === 1'b1) pulses++;
      n_checks++;
      if ({bus.f_q, bus.f_rise, bus.hit_cnt} !== e) begin
        n_errors++;
        $display("FAIL rise cyc=%0d got fq=%b rise=%b cnt=%0d want %b %b %0d",
                 k, bus.f_q, bus.f_rise, bus.hit_cnt, e.f_q, e.f_rise, e.hit_cnt);
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_errors++;
      $display("FAIL rise_count got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    apply(3'b000, 1'b0, 1'b1);
    tick();
    void'(sb.pop_front());
    for (int k = 0; k < 300; k++) begin
      apply(3'b111, 1'b0, 1'b0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({bus.f_q, bus.f_rise, bus.hit_cnt} !== e) begin
        n_errors++;
        $display("FAIL saturate cyc=%0d got cnt=%0d fq=%b rise=%b want %0d %b %b",
                 k, bus.hit_cnt, bus.f_q, bus.f_rise, e.hit_cnt, e.f_q, e.f_rise);
      end
    end
    n_checks++;
    if (bus.hit_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL saturate_final got %0d want 255", bus.hit_cnt);
    end
  endtask

  task automatic test_clear();
    exp_t e;
    apply(3'b000, 1'b0, 1'b1);
    tick();
    void'(sb.pop_front());
    // 10 counting cycles, a clear with f=1, then two more counting cycles.
    for (int k = 0; k < 13; k++) begin
      apply(3'b111, (k == 10), 1'b0);
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({bus.f_q, bus.f_rise, bus.hit_cnt} !== e) begin
        n_errors++;
        $display("FAIL clear cyc=%0d got cnt=%0d fq=%b rise=%b want %0d %b %b",
                 k, bus.hit_cnt, bus.f_q, bus.f_rise, e.hit_cnt, e.f_q, e.f_rise);
      end
      if (k == 10) begin
        n_checks++;
        if (bus.hit_cnt !== 8'd0) begin
          n_errors++;
          $display("FAIL clear_zero got %0d want 0", bus.hit_cnt);
        end
      end
      if (k == 11) begin
        n_checks++;
        if (bus.hit_cnt !== 8'd1) begin
          n_errors++;
          $display("FAIL clear_resume got %0d want 1", bus.hit_cnt);
        end
      end
    end
  endtask

  task automatic test_rst_clr();
    exp_t e;
    for (int k = 0; k < 6; k++) begin
      // Count up, then assert reset together with clear mid-stream.
      apply(3'b110, (k == 4), (k == 4));
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({bus.f_q, bus.f_rise, bus.hit_cnt} !== e) begin
        n_errors++;
        $display("FAIL rst_clr cyc=%0d got fq=%b rise=%b cnt=%0d want %b %b %0d",
                 k, bus.f_q, bus.f_rise, bus.hit_cnt, e.f_q, e.f_rise, e.hit_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [2:0] iv;
    for (int k = 0; k < 60; k++) begin
      iv = 3'($urandom_range(0, 7));
      apply(iv, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
      #1;
      n_checks++;
      if (bus.f !== exp_f) begin
        n_errors++;
        $display("FAIL b2b_f cyc=%0d i=%b got %b want %b", k, iv, bus.f, exp_f);
      end
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({bus.f_q, bus.f_rise, bus.hit_cnt} !== e) begin
        n_errors++;
        $display("FAIL b2b cyc=%0d got fq=%b rise=%b cnt=%0d want %b %b %0d",
                 k, bus.f_q, bus.f_rise, bus.hit_cnt, e.f_q, e.f_rise, e.hit_cnt);
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    tt          = 8'hE8;
    m_fq        = 1'b0;
    m_rise      = 1'b0;
    m_cnt       = '0;
    exp_f       = 1'b0;
    clk         = 1'b0;
    clk_en      = 1'b0;
    rst         = 1'b1;
    bus.i       = 3'b000;
    bus.cnt_clr = 1'b0;

    test_comb_sweep();
    test_parity();
    clk_en = 1'b1;
    tick();
    test_reset();
    test_rise();
    test_saturate();
    test_clear();
    test_rst_clr();
    test_back_to_back();

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
